// File: rtl/dec_pkg.sv
// Shared widths and constants for the 4-to-16 decoder.
package dec_pkg;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned OUT_W = 16;

    localparam logic [OUT_W-1:0] ONEHOT_ZERO = 16'h0000;

endpackage : dec_pkg

// File: rtl/dec_2x4.sv
// Combinational 2-to-4 one-hot decoder stage with active-high enable.
module dec_2x4 (
    input  logic       en,
    input  logic [1:0] in,
    output logic [3:0] out
);

    // One-hot select when enabled, all-zero otherwise.
    always_comb begin
        out = 4'b0000;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule : dec_2x4

// File: rtl/dec_4x16.sv
// Registered 4-to-16 one-hot decoder built from two levels of 2-to-4 stages.
module dec_4x16
    import dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    localparam int unsigned GRP_N = 4;
    localparam int unsigned GRP_W = 4;

    logic [GRP_N-1:0] grp_en;
    logic [OUT_W-1:0] d;

    // Upper code bits pick one group of four outputs.
    dec_2x4 u_grp (
        .en  (en),
        .in  (in[3:2]),
        .out (grp_en)
    );

    // Lower code bits pick the bit within each group; only the enabled group drives.
    for (genvar k = 0; k < GRP_N; k++) begin : g_sub
        dec_2x4 u_sub (
            .en  (grp_en[k]),
            .in  (in[1:0]),
            .out (d[GRP_W*k +: GRP_W])
        );
    end

    // Output register: loads the decode every edge, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= ONEHOT_ZERO;
        end else begin
            out <= d;
        end
    end

endmodule : dec_4x16

// File: tb/tb_dec_4x16.sv
// Directed and random self-checking bench for dec_4x16.
module tb_dec_4x16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  in;
    logic [15:0] out;

    int n_cmp = 0;
    int n_bad = 0;

    dec_4x16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference decode: set bit i when enabled.
    function automatic logic [15:0] model(input logic e, input logic [3:0] i);
        logic [15:0] r;
        r = 16'h0000;
        for (int b = 0; b < 16; b++) begin
            if (e && (b == int'(i))) r[b] = 1'b1;
        end
        return r;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        n_cmp++;
        assert (out === exp) else begin
            n_bad++;
            $error("FAIL %s: observed out=%h expected %h", tag, out, exp);
        end
    endtask

    task automatic check_pop(input string tag, input int exp);
        n_cmp++;
        assert ($countones(out) == exp) else begin
            n_bad++;
            $error("FAIL %s: observed popcount=%0d expected %0d (out=%h)",
                   tag, $countones(out), exp, out);
        end
    endtask

    initial begin
        logic       e_s;
        logic [3:0] i_s;
        logic [4:0] v;

        // Reset held with an active decode on the inputs.
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 4'h5;
        #1;
        check("reset_t0", 16'h0000);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("reset_hold", 16'h0000);
        end
        rst_n = 1'b1;
        #1;
        check("reset_release_pre_edge", 16'h0000);
        tick();
        check("reset_first_edge", 16'h0020);

        // Disabled sweep.
        en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in = 4'(k);
            tick();
            check("disabled_sweep", 16'h0000);
        end

        // Enabled sweep with a few hand-computed points.
        en = 1'b1;
        in = 4'h0; tick(); check("en_in0", 16'h0001);
        in = 4'h7; tick(); check("en_in7", 16'h0080);
        in = 4'hF; tick(); check("en_in15", 16'h8000);
        in = 4'h3; tick(); check("en_in3", 16'h0008);
        in = 4'hC; tick(); check("en_in12", 16'h1000);

        // Full {en,in} sweep with model and popcount checks.
        for (int k = 0; k < 32; k++) begin
            v  = 5'(k);
            en = v[4];
            in = v[3:0];
            tick();
            check("sweep32", model(v[4], v[3:0]));
            check_pop("sweep32_pop", int'(v[4]));
        end

        // Enable toggle at a fixed code.
        in = 4'hA;
        en = 1'b1; tick(); check("toggle_on1", 16'h0400);
        en = 1'b0; tick(); check("toggle_off", 16'h0000);
        en = 1'b1; tick(); check("toggle_on2", 16'h0400);

        // Simultaneous en/in change on the same edge.
        en = 1'b0; in = 4'h1; tick(); check("simul_a", 16'h0000);
        en = 1'b1; in = 4'h9; tick(); check("simul_b", 16'h0200);

        // Asynchronous reset between edges.
        en = 1'b1;
        in = 4'hF;
        tick();
        check("midrun_pre", 16'h8000);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_async_clear", 16'h0000);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrun_release_pre_edge", 16'h0000);
        tick();
        check("midrun_first_edge", 16'h8000);

        // Random cycles.
        for (int r = 0; r < 1000; r++) begin
            v   = 5'($urandom_range(0, 31));
            e_s = v[4];
            i_s = v[3:0];
            en  = e_s;
            in  = i_s;
            tick();
            check("random", model(e_s, i_s));
            check_pop("random_pop", int'(e_s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dec_4x16
